// File: rtl/bbox_scanner.sv
// Bounding-box pixel scanner: latches one triangle, clamps its bounding box to the screen,
// and emits every pixel in that box in row-major order, one per valid/ready handshake.
module bbox_scanner #(
    parameter int SYS_BIT_WIDTH = 10,
    parameter int H_PIXELS      = 320,
    parameter int V_PIXELS      = 240
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tri_valid_in,
    output logic                     tri_ready_out,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ax_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ay_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_bx_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_by_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cx_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cy_in,
    input  logic                     out_ready_in,
    output logic                     valid_out,
    output logic [SYS_BIT_WIDTH-1:0] point_x_out,
    output logic [SYS_BIT_WIDTH-1:0] point_y_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ax_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ay_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_bx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_by_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cy_out,
    output logic                     last_out,
    output logic                     done_out
);

    localparam logic [SYS_BIT_WIDTH-1:0] X_LIM = SYS_BIT_WIDTH'(H_PIXELS - 1);
    localparam logic [SYS_BIT_WIDTH-1:0] Y_LIM = SYS_BIT_WIDTH'(V_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, BBOX, SCAN} state_t;

    state_t                   r_state;
    logic [SYS_BIT_WIDTH-1:0] r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic [SYS_BIT_WIDTH-1:0] r_min_x, r_max_x, r_max_y;
    logic [SYS_BIT_WIDTH-1:0] r_cur_x, r_cur_y;
    logic                     r_valid, r_last, r_done;

    logic [SYS_BIT_WIDTH-1:0] w_min_x, w_min_y, w_raw_max_x, w_raw_max_y;
    logic [SYS_BIT_WIDTH-1:0] w_max_x, w_max_y;
    logic [SYS_BIT_WIDTH-1:0] w_next_x, w_next_y;
    logic                     w_empty;

    function automatic logic [SYS_BIT_WIDTH-1:0] min3(
        input logic [SYS_BIT_WIDTH-1:0] a,
        input logic [SYS_BIT_WIDTH-1:0] b,
        input logic [SYS_BIT_WIDTH-1:0] c
    );
        logic [SYS_BIT_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [SYS_BIT_WIDTH-1:0] max3(
        input logic [SYS_BIT_WIDTH-1:0] a,
        input logic [SYS_BIT_WIDTH-1:0] b,
        input logic [SYS_BIT_WIDTH-1:0] c
    );
        logic [SYS_BIT_WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    always_comb begin
        w_min_x     = min3(r_ax, r_bx, r_cx);
        w_min_y     = min3(r_ay, r_by, r_cy);
        w_raw_max_x = max3(r_ax, r_bx, r_cx);
        w_raw_max_y = max3(r_ay, r_by, r_cy);
        w_max_x     = (w_raw_max_x > X_LIM) ? X_LIM : w_raw_max_x;
        w_max_y     = (w_raw_max_y > Y_LIM) ? Y_LIM : w_raw_max_y;
        // Clamping only lowers max, so a min inside the screen always leaves max >= min.
        w_empty     = (w_min_x > X_LIM) || (w_min_y > Y_LIM);
        w_next_x    = r_cur_x + 1'b1;
        w_next_y    = r_cur_y + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_ax    <= '0;
            r_ay    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_min_x <= '0;
            r_max_x <= '0;
            r_max_y <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tri_valid_in) begin
                        r_ax    <= vertex_ax_in;
                        r_ay    <= vertex_ay_in;
                        r_bx    <= vertex_bx_in;
                        r_by    <= vertex_by_in;
                        r_cx    <= vertex_cx_in;
                        r_cy    <= vertex_cy_in;
                        r_state <= BBOX;
                    end
                end
                BBOX: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_min_x <= w_min_x;
                        r_max_x <= w_max_x;
                        r_max_y <= w_max_y;
                        r_cur_x <= w_min_x;
                        r_cur_y <= w_min_y;
                        r_valid <= 1'b1;
                        r_last  <= (w_min_x == w_max_x) && (w_min_y == w_max_y);
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    // last_out is registered, so it is computed for the point being moved to.
                    if (out_ready_in) begin
                        if (r_cur_x != r_max_x) begin
                            r_cur_x <= w_next_x;
                            r_last  <= (w_next_x == r_max_x) && (r_cur_y == r_max_y);
                        end else if (r_cur_y != r_max_y) begin
                            r_cur_x <= r_min_x;
                            r_cur_y <= w_next_y;
                            r_last  <= (r_min_x == r_max_x) && (w_next_y == r_max_y);
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tri_ready_out = (r_state == IDLE);
    assign valid_out     = r_valid;
    assign last_out      = r_last;
    assign done_out      = r_done;
    assign point_x_out   = r_cur_x;
    assign point_y_out   = r_cur_y;
    assign vertex_ax_out = r_ax;
    assign vertex_ay_out = r_ay;
    assign vertex_bx_out = r_bx;
    assign vertex_by_out = r_by;
    assign vertex_cx_out = r_cx;
    assign vertex_cy_out = r_cy;

endmodule

// File: tb/tb_bbox_scanner.sv
// Self-checking bench for bbox_scanner: directed test-plan scenarios plus random triangles,
// compared against a point list built from clamped min/max arithmetic.
module tb_bbox_scanner;

    localparam int W = 10;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         tri_valid_in;
    logic         tri_ready_out;
    logic [W-1:0] vertex_ax_in, vertex_ay_in, vertex_bx_in, vertex_by_in, vertex_cx_in, vertex_cy_in;
    logic         out_ready_in;
    logic         valid_out;
    logic [W-1:0] point_x_out, point_y_out;
    logic [W-1:0] vertex_ax_out, vertex_ay_out, vertex_bx_out, vertex_by_out, vertex_cx_out, vertex_cy_out;
    logic         last_out;
    logic         done_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bbox_scanner #(.SYS_BIT_WIDTH(W), .H_PIXELS(320), .V_PIXELS(240)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tri_valid_in  (tri_valid_in),
        .tri_ready_out (tri_ready_out),
        .vertex_ax_in  (vertex_ax_in),
        .vertex_ay_in  (vertex_ay_in),
        .vertex_bx_in  (vertex_bx_in),
        .vertex_by_in  (vertex_by_in),
        .vertex_cx_in  (vertex_cx_in),
        .vertex_cy_in  (vertex_cy_in),
        .out_ready_in  (out_ready_in),
        .valid_out     (valid_out),
        .point_x_out   (point_x_out),
        .point_y_out   (point_y_out),
        .vertex_ax_out (vertex_ax_out),
        .vertex_ay_out (vertex_ay_out),
        .vertex_bx_out (vertex_bx_out),
        .vertex_by_out (vertex_by_out),
        .vertex_cx_out (vertex_cx_out),
        .vertex_cy_out (vertex_cy_out),
        .last_out      (last_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int imin3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic int imax3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // mode 0: out_ready high; 1: random out_ready; 2: stall 3 cycles at (4,4) plus stray tri_valid
    task automatic run_triangle(input int ax, input int ay, input int bx, input int by,
                                input int cx, input int cy, input int mode, input string name,
                                output int n_out);
        int  mnx, mxx, mny, mxy, n, idx, c, done_c, first_c, last_hs, stalls, seen44, budget;
        bit  empty, done_seen;
        int  expx[$];
        int  expy[$];
        mnx = imin3(ax, bx, cx);
        mny = imin3(ay, by, cy);
        mxx = imax3(ax, bx, cx);
        mxy = imax3(ay, by, cy);
        if (mxx > 319) mxx = 319;
        if (mxy > 239) mxy = 239;
        empty = (mnx > 319) || (mny > 239);
        if (!empty)
            for (int y = mny; y <= mxy; y++)
                for (int x = mnx; x <= mxx; x++) begin
                    expx.push_back(x);
                    expy.push_back(y);
                end
        n = expx.size();
        n_out = n;

        total++;
        if (tri_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before: got %0b want 1", name, tri_ready_out);
        end
        vertex_ax_in = W'(ax); vertex_ay_in = W'(ay);
        vertex_bx_in = W'(bx); vertex_by_in = W'(by);
        vertex_cx_in = W'(cx); vertex_cy_in = W'(cy);
        tri_valid_in = 1'b1;
        out_ready_in = 1'b1;
        @(posedge clk_in); #1;
        tri_valid_in = 1'b0;
        c = 1; idx = 0; done_seen = 0; done_c = -1; first_c = -1; last_hs = -1;
        stalls = 0; seen44 = 0; budget = 4 * n + 20;

        while (!done_seen && c < budget) begin
            case (mode)
                0: out_ready_in = 1'b1;
                1: out_ready_in = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready_in = 1'b1;
                    if (valid_out && point_x_out == 4 && point_y_out == 4 && stalls < 3) begin
                        out_ready_in = 1'b0;
                        stalls++;
                    end
                end
            endcase
            if (mode == 2 && c == 6) begin
                tri_valid_in = 1'b1;
                vertex_ax_in = 100; vertex_ay_in = 100; vertex_bx_in = 0;
                vertex_by_in = 0;   vertex_cx_in = 50;  vertex_cy_in = 50;
            end else begin
                tri_valid_in = 1'b0;
            end

            if (c == 1) begin
                total++;
                if (valid_out !== 1'b0 || done_out !== 1'b0 || tri_ready_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s bbox_cycle: valid=%0b done=%0b ready=%0b want 0/0/0",
                             name, valid_out, done_out, tri_ready_out);
                end
            end

            if (valid_out === 1'b1) begin
                if (first_c < 0) first_c = c;
                if (point_x_out == 4 && point_y_out == 4) seen44++;
                total++;
                if (idx >= n) begin
                    bad++;
                    $display("FAIL %s extra_point: got (%0d,%0d) after %0d points",
                             name, point_x_out, point_y_out, n);
                end else if (point_x_out !== W'(expx[idx]) || point_y_out !== W'(expy[idx])) begin
                    bad++;
                    $display("FAIL %s point[%0d]: got (%0d,%0d) want (%0d,%0d)",
                             name, idx, point_x_out, point_y_out, expx[idx], expy[idx]);
                end
                total++;
                if (last_out !== (idx == n - 1)) begin
                    bad++;
                    $display("FAIL %s last[%0d]: got %0b want %0b", name, idx, last_out, (idx == n - 1));
                end
                total++;
                if (vertex_ax_out !== W'(ax) || vertex_ay_out !== W'(ay) || vertex_bx_out !== W'(bx) ||
                    vertex_by_out !== W'(by) || vertex_cx_out !== W'(cx) || vertex_cy_out !== W'(cy)) begin
                    bad++;
                    $display("FAIL %s vertices: got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)(%0d,%0d)",
                             name, vertex_ax_out, vertex_ay_out, vertex_bx_out, vertex_by_out,
                             vertex_cx_out, vertex_cy_out, ax, ay, bx, by, cx, cy);
                end
                total++;
                if (tri_ready_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_in_scan: got %0b want 0", name, tri_ready_out);
                end
                if (out_ready_in) begin
                    last_hs = c;
                    idx++;
                end
            end

            if (done_out === 1'b1) begin
                done_seen = 1;
                done_c = c;
                total++;
                if (tri_ready_out !== 1'b1 || valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_cycle_state: ready=%0b valid=%0b want 1/0",
                             name, tri_ready_out, valid_out);
                end
            end else begin
                @(posedge clk_in); #1;
                c++;
            end
        end
        tri_valid_in = 1'b0;
        out_ready_in = 1'b1;

        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL %s timeout: no done_out within %0d cycles", name, budget);
        end
        total++;
        if (idx != n) begin
            bad++;
            $display("FAIL %s point_count: got %0d want %0d", name, idx, n);
        end
        if (done_seen) begin
            if (empty) begin
                total++;
                if (done_c != 2 || first_c != -1) begin
                    bad++;
                    $display("FAIL %s empty_box: done at %0d first valid at %0d want 2 and none",
                             name, done_c, first_c);
                end
            end else begin
                total++;
                if (first_c != 2) begin
                    bad++;
                    $display("FAIL %s first_latency: got cycle %0d want 2", name, first_c);
                end
                total++;
                if (done_c != last_hs + 1) begin
                    bad++;
                    $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_c, last_hs + 1);
                end
                if (mode == 0) begin
                    total++;
                    if (done_c != n + 2) begin
                        bad++;
                        $display("FAIL %s done_latency: got cycle %0d want %0d", name, done_c, n + 2);
                    end
                end
            end
        end
        if (mode == 2) begin
            total++;
            if (seen44 != 4) begin
                bad++;
                $display("FAIL %s hold_44: got %0d cycles want 4", name, seen44);
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; tri_valid_in = 1'b0; out_ready_in = 1'b1;
        vertex_ax_in = '0; vertex_ay_in = '0; vertex_bx_in = '0;
        vertex_by_in = '0; vertex_cx_in = '0; vertex_cy_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        total++;
        if (valid_out !== 1'b0 || last_out !== 1'b0 || done_out !== 1'b0 || tri_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%0b last=%0b done=%0b ready=%0b want 0/0/0/1",
                     valid_out, last_out, done_out, tri_ready_out);
        end
        total++;
        if (point_x_out !== '0 || point_y_out !== '0 || vertex_ax_out !== '0 || vertex_ay_out !== '0 ||
            vertex_bx_out !== '0 || vertex_by_out !== '0 || vertex_cx_out !== '0 || vertex_cy_out !== '0) begin
            bad++;
            $display("FAIL reset_data: point=(%0d,%0d) va=(%0d,%0d) want zeros",
                     point_x_out, point_y_out, vertex_ax_out, vertex_ay_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int  c, n;
        bit  hit;
        vertex_ax_in = 2; vertex_ay_in = 3; vertex_bx_in = 5;
        vertex_by_in = 3; vertex_cx_in = 2; vertex_cy_in = 6;
        tri_valid_in = 1'b1; out_ready_in = 1'b1;
        @(posedge clk_in); #1;
        tri_valid_in = 1'b0;
        c = 1; hit = 0;
        while (!hit && c < 40) begin
            if (valid_out && point_x_out == 3 && point_y_out == 5) hit = 1;
            else begin
                @(posedge clk_in); #1;
                c++;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midrst_reach: point (3,5) not seen within 40 cycles");
        end
        #2 rst_in = 1'b1;
        #1;
        total++;
        if (valid_out !== 1'b0 || done_out !== 1'b0 || last_out !== 1'b0 || tri_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL midrst_async: valid=%0b done=%0b last=%0b ready=%0b want 0/0/0/1",
                     valid_out, done_out, last_out, tri_ready_out);
        end
        @(posedge clk_in); #1;
        total++;
        if (done_out !== 1'b0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_done: done=%0b valid=%0b want 0/0", done_out, valid_out);
        end
        rst_in = 1'b0;
        run_triangle(10, 20, 12, 20, 10, 22, 0, "after_reset", n);
    endtask

    task automatic test_random();
        int ax, ay, bx, by, cx, cy, bxs, bys, n;
        for (int t = 0; t < 10; t++) begin
            bxs = $urandom_range(0, 335);
            bys = $urandom_range(0, 245);
            ax = bxs + $urandom_range(0, 10); ay = bys + $urandom_range(0, 10);
            bx = bxs + $urandom_range(0, 10); by = bys + $urandom_range(0, 10);
            cx = bxs + $urandom_range(0, 10); cy = bys + $urandom_range(0, 10);
            run_triangle(ax, ay, bx, by, cx, cy, (t % 3 == 0) ? 0 : 1, "random", n);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, n3, t0;
        t0 = cyc;
        run_triangle(1, 1, 3, 1, 1, 2, 0, "b2b_a", n1);
        run_triangle(318, 238, 330, 250, 318, 238, 0, "b2b_b", n2);
        run_triangle(9, 9, 9, 9, 9, 9, 0, "b2b_c", n3);
        total++;
        if (cyc - t0 != (n1 + 2) + (n2 + 2) + (n3 + 2)) begin
            bad++;
            $display("FAIL b2b_throughput: got %0d cycles want %0d", cyc - t0, n1 + n2 + n3 + 6);
        end
    endtask

    initial begin
        int n;
        test_reset();
        @(posedge clk_in); #1;
        run_triangle(2, 3, 5, 3, 2, 6, 0, "basic", n);
        run_triangle(7, 7, 7, 7, 7, 7, 0, "single_point", n);
        run_triangle(300, 10, 400, 10, 300, 11, 0, "clamp", n);
        run_triangle(330, 5, 340, 5, 335, 9, 0, "offscreen", n);
        run_triangle(2, 3, 5, 3, 2, 6, 2, "backpressure", n);
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bbox_scanner.md
# bbox_scanner

Pixel-iteration stage that sits directly upstream of `in_triangle_wrap` in the fp-3D rasterizer. It accepts one screen-space triangle at a time through a valid/ready handshake and computes the triangle's axis-aligned bounding box, clamped to the screen. It then emits every pixel coordinate in that box in row-major order, together with the latched vertices, so the in-triangle test receives one candidate point per cycle.

## Interface
- `SYS_BIT_WIDTH`, 10: width of every coordinate, unsigned.
- `H_PIXELS`, 320: screen width; valid x is 0..H_PIXELS-1.
- `V_PIXELS`, 240: screen height; valid y is 0..V_PIXELS-1.

- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `tri_valid_in`  in  1  triangle vertices valid.
- `tri_ready_out`  out  1  block can accept a triangle; combinational, equals (state==IDLE).
- `vertex_ax_in`, `vertex_ay_in`, `vertex_bx_in`, `vertex_by_in`, `vertex_cx_in`, `vertex_cy_in`  in  SYS_BIT_WIDTH each  triangle vertices.
- `out_ready_in`  in  1  downstream accepts the current point; tie high when driving `in_triangle_wrap`.
- `valid_out`  out  1  `point_x_out`/`point_y_out` hold a valid candidate pixel.
- `point_x_out`, `point_y_out`  out  SYS_BIT_WIDTH  candidate pixel.
- `vertex_ax_out` .. `vertex_cy_out`  out  SYS_BIT_WIDTH each  latched vertices, stable for the entire scan.
- `last_out`  out  1  high with `valid_out` on the final pixel of the box.
- `done_out`  out  1  one-cycle pulse when the triangle is finished.

## Operation
- FSM states: IDLE, BBOX, SCAN.
- **IDLE**
  - `tri_ready_out`=1.
  - On `tri_valid_in`: latch all six vertices into the `vertex_*_out` registers, then go to BBOX.
- **BBOX** (exactly one cycle)
  - Compute unsigned min/max of the three x values and of the three y values.
  - Clamp: max_x = min(max_x, H_PIXELS-1) and max_y = min(max_y, V_PIXELS-1).
  - If min_x > H_PIXELS-1 or min_y > V_PIXELS-1, the box is empty:
    - pulse `done_out` next cycle;
    - return to IDLE;
    - emit no points.
  - Otherwise load cur_x=min_x and cur_y=min_y, then go to SCAN.
- **SCAN**
  - `valid_out`=1 and point = (cur_x, cur_y).
  - A point advances only on `valid_out && out_ready_in`. Without that handshake, point, `last_out` and state hold.
  - Advance rules:
    - If cur_x != max_x: cur_x+1.
    - Else if cur_y != max_y: cur_x=min_x and cur_y+1.
    - Else (the last point): go to IDLE and pulse `done_out` next cycle.
  - `last_out` = (cur_x==max_x && cur_y==max_y) while in SCAN.
- Pixel count per triangle = (max_x-min_x+1)*(max_y-min_y+1).
- Vertex order and winding are irrelevant to this block.
- Degenerate triangles (collinear or coincident vertices) are scanned like any other box.
- Comparisons use SYS_BIT_WIDTH unsigned arithmetic. No point ever exceeds max_x/max_y, so the counters never wrap.
- `tri_valid_in` while not in IDLE is ignored; `tri_ready_out`=0 and nothing is latched.

## Timing
- Reset values:
  - state=IDLE;
  - `valid_out`, `last_out`, `done_out` = 0;
  - point and vertex outputs = 0;
  - `tri_ready_out`=1 once in IDLE.
- Reset asserted mid-scan clears `valid_out` immediately, with no completion `done_out` pulse.
- Latency, with cycle 0 being the cycle the triangle handshake is sampled:
  - cycle 1: BBOX;
  - cycle 2: first point valid;
  - one point per cycle while `out_ready_in`=1.
- `done_out` is asserted in the cycle after the last point handshake; `tri_ready_out`=1 in that same cycle.
- Empty box: `done_out` at cycle 2, no `valid_out`.
- Back-to-back throughput with `out_ready_in` held high is N pixels + 2 cycles per triangle.
- All outputs except `tri_ready_out` are registered.

## Test plan
1. Vertices (2,3),(5,3),(2,6), `out_ready_in`=1:
   - 16 points, (2,3),(3,3)..(5,3),(2,4)..(5,6);
   - first point at cycle 2;
   - `last_out` only on (5,6);
   - `done_out` exactly once, one cycle later.
2. All vertices (7,7):
   - single point (7,7) with `valid_out` and `last_out` both high;
   - `done_out` next cycle.
3. Clamp, vertices (300,10),(400,10),(300,11):
   - x 300..319, y 10..11, 40 points;
   - no point with x ≥ 320.
4. Off-screen, vertices (330,5),(340,5),(335,9):
   - zero `valid_out` cycles;
   - `done_out` at cycle 2;
   - `tri_ready_out` high again at cycle 2.
5. Backpressure: triangle from test 1, `out_ready_in` low for 3 cycles while the point is (4,4):
   - (4,4) held for 4 cycles;
   - sequence still exactly 16 points, no skips or duplicates;
   - a `tri_valid_in` pulse during the scan is ignored.
6. Reset mid-scan: assert `rst_in` at point (3,5):
   - `valid_out` drops asynchronously, with no `done_out` pulse;
   - after release, a new triangle is accepted and scanned from its own min corner.
